// File: rtl/ic_pkg.sv
// Shared types for the interconnect request arbiter: FSM encoding and master indices.
package ic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } ic_state_e;

    localparam logic IC_M_INSTR = 1'b0;
    localparam logic IC_M_DATA  = 1'b1;

endpackage

// File: rtl/ic_rr_pick.sv
// 2-way round-robin selector: the sole requester wins, a tie goes to the master that did not win last.
// Latency: combinational. Backpressure: none, pure function of req and last_grant.
module ic_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       any
);

    assign any    = |req;
    assign winner = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/ic_req_arbiter.sv
// Two-master (ifetch m0, data m1) round-robin arbiter, one outstanding transaction; IC_ARB_TIMEOUT_EN adds a response watchdog.
// Latency: gnt in the request cycle, request at fabric 1 cycle later, response forwarded combinationally.
// Backpressure: no gnt outside IDLE; registered s_* held stable until s_gnt.
module ic_req_arbiter
    import ic_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            m0_req,
    output logic            m0_gnt,
    input  logic [AW-1:0]   m0_addr,
    output logic            m0_rsp_valid,
    output logic            m0_rsp_err,
    output logic [DW-1:0]   m0_rsp_rdata,
    input  logic            m1_req,
    output logic            m1_gnt,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_wen,
    input  logic [DW/8-1:0] m1_strb,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_rsp_valid,
    output logic            m1_rsp_err,
    output logic [DW-1:0]   m1_rsp_rdata,
    output logic            s_req,
    input  logic            s_gnt,
    output logic [AW-1:0]   s_addr,
    output logic            s_wen,
    output logic [DW/8-1:0] s_strb,
    output logic [DW-1:0]   s_wdata,
    input  logic            s_rsp_valid,
    input  logic            s_rsp_err,
    input  logic [DW-1:0]   s_rsp_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    ic_state_e       state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW/8-1:0] strb_q, strb_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic            win, any;
    logic            rsp_fire, rsp_to, rsp_vld, rsp_err;
    logic [DW-1:0]   rsp_rdata;

    ic_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .winner     (win),
        .any        (any)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        strb_d       = strb_q;
        wdata_d      = wdata_q;
        rsp_fire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    owner_d      = win;
                    last_grant_d = win;
                    state_d      = REQ;
                    if (win == IC_M_DATA) begin
                        addr_d  = m1_addr;
                        wen_d   = m1_wen;
                        strb_d  = m1_strb;
                        wdata_d = m1_wdata;
                    end else begin
                        addr_d  = m0_addr;
                        wen_d   = 1'b0;
                        strb_d  = '0;
                        wdata_d = '0;
                    end
                end
            end
            REQ: begin
                // A response is only meaningful once the fabric has taken the request.
                if (s_gnt) begin
                    if (s_rsp_valid) begin
                        rsp_fire = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = RSP;
                    end
                end
            end
            RSP: begin
                if (s_rsp_valid) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rsp_to) state_d = IDLE;
    end

`ifdef IC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = (state_q == IDLE) ? '0 : to_cnt_q + TW'(1);
        // A real response in the expiry cycle takes priority over the watchdog.
        rsp_to   = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES)) && !rsp_fire;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`else
    assign rsp_to = 1'b0;
`endif

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q      <= IDLE;
            owner_q      <= IC_M_INSTR;
            last_grant_q <= IC_M_DATA;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            strb_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            strb_q       <= strb_d;
            wdata_q      <= wdata_d;
        end
    end

    assign m0_gnt = !g_reset && (state_q == IDLE) && any && (win == IC_M_INSTR);
    assign m1_gnt = !g_reset && (state_q == IDLE) && any && (win == IC_M_DATA);

    assign s_req   = (state_q == REQ);
    assign s_addr  = addr_q;
    assign s_wen   = wen_q;
    assign s_strb  = strb_q;
    assign s_wdata = wdata_q;

    assign rsp_vld   = rsp_fire | rsp_to;
    assign rsp_err   = rsp_to | s_rsp_err;
    assign rsp_rdata = rsp_to ? '0 : s_rsp_rdata;

    assign m0_rsp_valid = rsp_vld && (owner_q == IC_M_INSTR);
    assign m0_rsp_err   = m0_rsp_valid && rsp_err;
    assign m0_rsp_rdata = m0_rsp_valid ? rsp_rdata : '0;
    assign m1_rsp_valid = rsp_vld && (owner_q == IC_M_DATA);
    assign m1_rsp_err   = m1_rsp_valid && rsp_err;
    assign m1_rsp_rdata = m1_rsp_valid ? rsp_rdata : '0;

endmodule
